// File: rtl/accel_avg_filter_pkg.sv
// Shared definitions for the accelerometer moving-average filter.
//  - ACC_WIDTH / ACC_LOG2_DEPTH : default sample width and log2 window length
//  - state_e                    : FSM encoding (ST_FLUSH=0, ST_RUN=1), also
//                                 consumed by the downstream game logic
package accel_avg_filter_pkg;

   localparam int ACC_WIDTH      = 16;
   localparam int ACC_LOG2_DEPTH = 3;

   typedef enum logic {
      ST_FLUSH = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

endpackage

// File: rtl/accel_avg_filter_if.sv
// Sample/average bundle between the accelerometer front end and the filter.
//  master : drives sample_in, sample_valid, clear; sees avg_out, avg_valid, primed, busy
//  slave  : the filter side
interface accel_avg_filter_if import accel_avg_filter_pkg::*; #(
   parameter int WIDTH = ACC_WIDTH
) ();

   logic [WIDTH-1:0] sample_in;
   logic             sample_valid;
   logic             clear;
   logic [WIDTH-1:0] avg_out;
   logic             avg_valid;
   logic             primed;
   logic             busy;

   modport master (
      output sample_in, sample_valid, clear,
      input  avg_out, avg_valid, primed, busy
   );

   modport slave (
      input  sample_in, sample_valid, clear,
      output avg_out, avg_valid, primed, busy
   );

endinterface

// File: rtl/accel_sample_ram.sv
// Circular sample buffer: DEPTH x WIDTH, one asynchronous read port and one
// synchronous write port sharing the address, so a read and a write to the
// same entry in one cycle returns the old contents. No reset: the filter's
// FLUSH state is what zeroes it.
//  clk   : clock
//  we    : write enable
//  addr  : read/write address
//  wdata : write data
//  rdata : current contents of mem[addr]
module accel_sample_ram import accel_avg_filter_pkg::*; #(
   parameter int WIDTH      = ACC_WIDTH,
   parameter int LOG2_DEPTH = ACC_LOG2_DEPTH
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [LOG2_DEPTH-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem_q [1<<LOG2_DEPTH];

   assign rdata = mem_q[addr];

   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
   end

endmodule

// File: rtl/accel_avg_filter.sv
// Moving-average smoother for signed accelerometer samples. Keeps the last
// 2**LOG2_DEPTH accepted samples in a ring buffer and a running sum, and
// publishes floor(sum / DEPTH) one cycle after each accepted sample.
//  clk, rst : clock, synchronous active-high reset
//  bus      : slave side of accel_avg_filter_if
//             sample_in/sample_valid/clear in; avg_out/avg_valid/primed/busy out
module accel_avg_filter import accel_avg_filter_pkg::*; #(
   parameter int WIDTH      = ACC_WIDTH,
   parameter int LOG2_DEPTH = ACC_LOG2_DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   accel_avg_filter_if.slave  bus
);

   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int SUM_W = WIDTH + LOG2_DEPTH;

   typedef logic [LOG2_DEPTH-1:0] ptr_t;
   typedef logic [LOG2_DEPTH:0]   fill_t;

   state_e                   state_q,     state_d;
   ptr_t                     wr_ptr_q,    wr_ptr_d;
   fill_t                    fill_cnt_q,  fill_cnt_d;
   logic signed [SUM_W-1:0]  sum_q,       sum_d;
   logic [WIDTH-1:0]         avg_out_q,   avg_out_d;
   logic                     avg_valid_q, avg_valid_d;
   logic                     primed_q,    primed_d;

   logic                     ram_we;
   logic [WIDTH-1:0]         ram_wdata;
   logic [WIDTH-1:0]         old_sample;
   logic signed [SUM_W-1:0]  new_ext, old_ext;

   accel_sample_ram #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (wr_ptr_q),
      .wdata (ram_wdata),
      .rdata (old_sample)
   );

   assign new_ext = {{LOG2_DEPTH{bus.sample_in[WIDTH-1]}}, bus.sample_in};
   assign old_ext = {{LOG2_DEPTH{old_sample[WIDTH-1]}},    old_sample};

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      fill_cnt_d  = fill_cnt_q;
      sum_d       = sum_q;
      avg_out_d   = avg_out_q;
      avg_valid_d = 1'b0;
      primed_d    = primed_q;
      ram_we      = 1'b0;
      ram_wdata   = '0;
      case (state_q)
         ST_FLUSH: begin
            // Zero one entry per cycle; inputs are ignored until the ring is clean.
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == ptr_t'(DEPTH-1)) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.clear) begin
               state_d    = ST_FLUSH;
               wr_ptr_d   = '0;
               fill_cnt_d = '0;
               sum_d      = '0;
               avg_out_d  = '0;
               primed_d   = 1'b0;
            end else if (bus.sample_valid) begin
               ram_we    = 1'b1;
               ram_wdata = bus.sample_in;
               wr_ptr_d  = wr_ptr_q + 1'b1;
               // Swap the oldest sample out of the running sum.
               sum_d     = sum_q + new_ext - old_ext;
               if (fill_cnt_q != fill_t'(DEPTH)) fill_cnt_d = fill_cnt_q + 1'b1;
               // Dropping the low bits of a two's-complement sum is an
               // arithmetic shift, i.e. floor toward -inf; the top WIDTH bits
               // always fit because |sum| <= DEPTH * 2**(WIDTH-1).
               avg_out_d   = sum_d[SUM_W-1:LOG2_DEPTH];
               avg_valid_d = 1'b1;
               primed_d    = (fill_cnt_d == fill_t'(DEPTH));
            end
         end
         default: state_d = ST_FLUSH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_FLUSH;
         wr_ptr_q    <= '0;
         fill_cnt_q  <= '0;
         sum_q       <= '0;
         avg_out_q   <= '0;
         avg_valid_q <= 1'b0;
         primed_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         fill_cnt_q  <= fill_cnt_d;
         sum_q       <= sum_d;
         avg_out_q   <= avg_out_d;
         avg_valid_q <= avg_valid_d;
         primed_q    <= primed_d;
      end
   end

   assign bus.avg_out   = avg_out_q;
   assign bus.avg_valid = avg_valid_q;
   assign bus.primed    = primed_q;
   assign bus.busy      = (state_q == ST_FLUSH);

endmodule
